uart_rx_frame_loader: RTL and testbench

//  Receive-side counterpart of the pixel UART TX path: deserializes 8N1 UART bytes from the host
//  and writes them sequentially into a packed 1-bpp frame RAM (8 pixels/byte, LSB = leftmost pixel).

---
 rtl/uart_rx_frame_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_frame_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_loader.sv
// 8N1 UART receiver (16x oversampled) that streams bytes into a packed 1-bpp frame RAM.
// Latency: write strobe one clock after the stop-bit sample, about 9.5 bit times after the start edge.
// Backpressure: none; the RAM write port must accept one write per byte time.
`timescale 1ns/1ps
module uart_rx_frame_loader #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int FRAME_BYTES  = 5100,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx,
    output logic                           we,
    output logic [$clog2(FRAME_BYTES)-1:0] wAddr,
    output logic [7:0]                     wData,
    output logic                           frame_done,
    output logic                           frame_err,
    output logic                           sync_err,
    output logic                           rx_busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FRAME_BYTES);
    localparam int TW  = $clog2(TIMEOUT_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic          rx_meta;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    state_t        state;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [3:0]    to_sub;
    logic [TW-1:0] to_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            s_cnt      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            to_sub     <= '0;
            to_bits    <= '0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;

            if (we) begin
                wAddr <= (wAddr == LAST_ADDR) ? '0 : wAddr + AW'(1);
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state   <= START;
                            s_cnt   <= '0;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (s_cnt == 4'd7) begin
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state   <= DATA;
                                s_cnt   <= '0;
                                bit_cnt <= '0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (s_cnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            s_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            if (rx_s) begin
                                we         <= 1'b1;
                                wData      <= shreg;
                                frame_done <= (wAddr == LAST_ADDR);
                                state      <= IDLE;
                                rx_busy    <= 1'b0;
                            end else begin
                                // Bad stop bit: drop the byte and wait out a possible line break.
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end

            // Idle watchdog only runs mid-frame; leaving IDLE (start detect) clears it.
            if (state != IDLE || wAddr == '0) begin
                to_sub  <= '0;
                to_bits <= '0;
            end else if (tick) begin
                if (to_sub == 4'd15) begin
                    to_sub <= '0;
                    if (to_bits == TO_LAST) begin
                        to_bits  <= '0;
                        sync_err <= 1'b1;
                        wAddr    <= '0;
                    end else begin
                        to_bits <= to_bits + TW'(1);
                    end
                end else begin
                    to_sub <= to_sub + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_loader.sv
// Directed bench for uart_rx_frame_loader: byte-level model of expected RAM writes and error pulses,
// compared against the DUT on every falling clock edge, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_frame_loader;

    localparam int BAUD     = 115_200;
    localparam int CLK_FREQ = 16 * BAUD * 4;
    localparam int FB       = 4;
    localparam int TOB      = 20;
    localparam int BIT      = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       we;
    logic [1:0] wAddr;
    logic [7:0] wData;
    logic       frame_done;
    logic       frame_err;
    logic       sync_err;
    logic       rx_busy;

    uart_rx_frame_loader #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .FRAME_BYTES(FB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .we(we),
        .wAddr(wAddr),
        .wData(wData),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .sync_err(sync_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: expected writes as {addr, data, frame_done}, pending error pulses.
    logic [10:0] exp_q[$];
    logic [10:0] exp_e;
    int          model_addr = 0;
    int          ferr_pend  = 0;
    int          serr_pend  = 0;
    int          done_cnt   = 0;
    int          ferr_cnt   = 0;
    int          last_we_cyc = 0;
    int          sync_cyc   = 0;
    logic [1:0]  last_addr  = 2'd0;
    logic [7:0]  last_data  = 8'd0;

    always @(negedge clk) begin
        if (reset) begin
            if (we) begin
                last_we_cyc = cyc;
                last_addr   = wAddr;
                last_data   = wData;
                check("we_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("write_addr_data_done", {wAddr, wData, frame_done}, exp_e);
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_with_we", we, 1);
            end
            if (frame_err) begin
                ferr_cnt++;
                check("frame_err_expected", 32'(ferr_pend > 0), 1);
                if (ferr_pend > 0) ferr_pend--;
            end
            if (sync_err) begin
                sync_cyc = cyc;
                check("sync_err_expected", 32'(serr_pend > 0), 1);
                if (serr_pend > 0) serr_pend--;
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back({2'(model_addr), b, 1'(model_addr == FB - 1)});
            model_addr = (model_addr + 1) % FB;
        end else begin
            ferr_pend++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    // Long gaps mid-frame (well past TIMEOUT_BITS) must resync the address; short ones must not.
    task automatic idle_bits(input int n);
        if (n > TOB + 2 && model_addr != 0) begin
            serr_pend++;
            model_addr = 0;
        end
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    int         t0;
    int         lat;
    logic       saw_busy;
    logic       dropped;
    logic [7:0] rb = 8'hC3;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_outputs_zero", {we, wAddr, wData, frame_done, frame_err, sync_err, rx_busy}, 0);
        reset = 1'b1;
        idle_bits(2);

        // Single byte: latency and content.
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        lat = last_we_cyc - t0;
        check($sformatf("a5_latency_%0d_in_604_620", lat), 32'(lat >= 604 && lat <= 620), 1);
        check("a5_addr", last_addr, 2'd0);
        check("a5_data", last_data, 8'hA5);
        check("a5_busy_low_after", rx_busy, 0);
        idle_bits(25);
        check("a5_idle_sync_seen", serr_pend, 0);

        // Full frame back-to-back, then wrap.
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check("frame_last_addr", last_addr, 2'd3);
        check("frame_last_data", last_data, 8'h04);
        check("frame_done_count", done_cnt, 1);
        send_byte(8'h05, 1'b1);
        check("wrap_addr", last_addr, 2'd0);
        check("wrap_data", last_data, 8'h05);
        idle_bits(2);

        // Bad stop bit: no write, address held.
        send_byte(8'h3C, 1'b0);
        idle_bits(2);
        check("ferr_pulse_count", ferr_cnt, 1);
        send_byte(8'h77, 1'b1);
        check("after_ferr_addr", last_addr, 2'd1);
        check("after_ferr_data", last_data, 8'h77);
        send_byte(8'h78, 1'b1);
        idle_bits(2);

        // Start-bit glitch of 3 ticks.
        saw_busy = 1'b0;
        dropped  = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 32 && !dropped; i++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
            else if (saw_busy) dropped = 1'b1;
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_busy_dropped", dropped, 1);
        idle_bits(2);

        // Mid-frame timeout.
        send_byte(8'h11, 1'b1);
        check("done_count_second_frame", done_cnt, 2);
        send_byte(8'h22, 1'b1);
        idle_bits(25);
        check("timeout_sync_seen", serr_pend, 0);
        lat = sync_cyc - last_we_cyc;
        check($sformatf("timeout_delay_%0d_in_1276_1284", lat), 32'(lat >= 1276 && lat <= 1284), 1);
        check("timeout_waddr_zero", wAddr, 2'd0);
        send_byte(8'h99, 1'b1);
        check("after_timeout_addr", last_addr, 2'd0);
        check("after_timeout_data", last_data, 8'h99);

        // Reset during data bit 4.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        rx = rb[4];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        #1;
        check("midbyte_reset_outputs_zero", {we, wAddr, wData, frame_done, frame_err, sync_err, rx_busy}, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        model_addr = 0;
        idle_bits(2);
        send_byte(8'h5A, 1'b1);
        check("after_reset_addr", last_addr, 2'd0);
        check("after_reset_data", last_data, 8'h5A);
        idle_bits(2);

        check("writes_drained", exp_q.size(), 0);
        check("ferr_drained", ferr_pend, 0);
        check("serr_drained", serr_pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
